// File: rtl/mem_bus_arbiter_pkg.sv
// ============================================================================
// mem_bus_arbiter_pkg : shared state codes, SIZE codes and helpers for the arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_I_BUS = 2'd1,
        ST_D_BUS = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int TIMEOUT_DEFAULT = 16;

    // True when the access must be rejected without touching the bus.
    function automatic logic addr_fault(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lsb[0];
            SZ_WORD: return (lsb != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_bus_arbiter_timeout_cnt.sv
// ============================================================================
// mem_bus_arbiter_timeout_cnt : bus-cycle wait counter, flags the last allowed cycle
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_bus_arbiter_timeout_cnt #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TO_W-1:0] LAST_COUNT = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + TO_W'(1);
        end
    end

    // Reaching LAST_COUNT without ACK means bus_req has been up TIMEOUT cycles.
    assign expired = (count == LAST_COUNT);

endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// mem_bus_arbiter : shares one memory bus between fetch and data, data first
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int TO_W    = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    output logic        if_stall,
    input  logic        d_req,
    input  logic        d_write,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        d_stall,
    output logic        bus_req,
    output logic        bus_write,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack_n
);

    state_t state, state_nxt;
    logic   take_d, take_i, go_done, done_err, done_to_d;
    logic   bus_phase, to_expired, d_bad, i_bad;

    assign d_bad     = addr_fault(d_size, d_addr[1:0]);
    assign i_bad     = addr_fault(SZ_WORD, if_addr[1:0]);
    assign bus_phase = (state == ST_I_BUS) || (state == ST_D_BUS);

    // Stalls are gated by reset so every output reads 0 while rst is low.
    assign if_stall = rst & if_req & ~if_valid;
    assign d_stall  = rst & d_req & ~d_valid;

    mem_bus_arbiter_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (take_d | take_i),
        .enable  (bus_phase & bus_ack_n),
        .expired (to_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        take_d    = 1'b0;
        take_i    = 1'b0;
        go_done   = 1'b0;
        done_err  = 1'b0;
        done_to_d = (state == ST_D_BUS);
        case (state)
            ST_IDLE: begin
                if (d_req) begin
                    take_d    = 1'b1;
                    done_to_d = 1'b1;
                    if (d_bad) begin
                        state_nxt = ST_DONE;
                        go_done   = 1'b1;
                        done_err  = 1'b1;
                    end else begin
                        state_nxt = ST_D_BUS;
                    end
                end else if (if_req) begin
                    take_i = 1'b1;
                    if (i_bad) begin
                        state_nxt = ST_DONE;
                        go_done   = 1'b1;
                        done_err  = 1'b1;
                    end else begin
                        state_nxt = ST_I_BUS;
                    end
                end
            end
            ST_I_BUS, ST_D_BUS: begin
                // An ACK on the final allowed cycle still wins over the abort.
                if (!bus_ack_n) begin
                    state_nxt = ST_DONE;
                    go_done   = 1'b1;
                end else if (to_expired) begin
                    state_nxt = ST_DONE;
                    go_done   = 1'b1;
                    done_err  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_req   <= 1'b0;
            bus_write <= 1'b0;
            bus_size  <= 2'b00;
            bus_addr  <= '0;
            bus_wdata <= '0;
            if_valid  <= 1'b0;
            if_rdata  <= '0;
            if_err    <= 1'b0;
            d_valid   <= 1'b0;
            d_rdata   <= '0;
            d_err     <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            bus_req  <= (state_nxt == ST_I_BUS) || (state_nxt == ST_D_BUS);
            if (take_d) begin
                bus_addr  <= d_addr;
                bus_size  <= d_size;
                bus_write <= d_write;
                bus_wdata <= d_wdata;
            end else if (take_i) begin
                bus_addr  <= if_addr;
                bus_size  <= SZ_WORD;
                bus_write <= 1'b0;
                bus_wdata <= '0;
            end
            if (go_done) begin
                if (done_to_d) begin
                    d_valid <= 1'b1;
                    d_err   <= done_err;
                    d_rdata <= (done_err || bus_write) ? 32'h0 : bus_rdata;
                end else begin
                    // A flushed fetch still finishes on the bus but reports nothing.
                    if_valid <= if_req;
                    if_err   <= done_err;
                    if_rdata <= done_err ? 32'h0 : bus_rdata;
                end
            end
        end
    end

    a_d_req_held : assert property (@(posedge clk) disable iff (!rst)
        (state == ST_D_BUS) |-> d_req);

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// tb_mem_bus_arbiter : directed scoreboard bench for mem_bus_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_valid, if_err, if_stall;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0, d_write = 1'b0;
    logic [1:0]  d_size = 2'b00;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic        d_valid, d_err, d_stall;
    logic [31:0] d_rdata;
    logic        bus_req, bus_write;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_ack_n = 1'b1;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: fixed word at 0x100, address-derived pattern elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h100) ? 32'h0000_0013 : {a[15:0], ~a[15:0]};
    endfunction
    assign bus_rdata = mem_word(bus_addr);

    mem_bus_arbiter #(.TIMEOUT(16), .TO_W(5)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
        .if_err(if_err), .if_stall(if_stall),
        .d_req(d_req), .d_write(d_write), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
        .d_stall(d_stall),
        .bus_req(bus_req), .bus_write(bus_write), .bus_size(bus_size),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_ack_n(bus_ack_n)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    endtask

    task automatic push(input bit is_d, input logic [31:0] rd, input logic er);
        exp_t e;
        e.is_d = is_d; e.rdata = rd; e.err = er;
        sb.push_back(e);
    endtask

    task automatic score(input bit is_d, input logic [31:0] rd, input logic er);
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_nonempty", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        check(is_d ? "port_d" : "port_if", {31'b0, is_d}, {31'b0, e.is_d});
        check(is_d ? "d_rdata" : "if_rdata", rd, e.rdata);
        check(is_d ? "d_err" : "if_err", {31'b0, er}, {31'b0, e.err});
    endtask

    always @(negedge clk) begin
        if (rst && if_valid) score(1'b0, if_rdata, if_err);
        if (rst && d_valid)  score(1'b1, d_rdata, d_err);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d_t, i_t, hi, vcnt;
        logic [31:0] seen_addr;
        logic [1:0]  bad_sz [3];
        logic [31:0] bad_ad [3];
        bad_sz = '{2'b10, 2'b01, 2'b11};
        bad_ad = '{32'h2002, 32'h5001, 32'h5000};

        // Reset values
        #12;
        check("rst_outputs", {27'b0, bus_req, if_valid, d_valid, if_stall, d_stall}, 32'h0);
        check("rst_bus_addr", bus_addr, 32'h0);
        @(negedge clk) rst = 1'b1;

        // Reset mid-transaction
        @(negedge clk);
        d_req = 1'b1; d_write = 1'b0; d_size = 2'b10; d_addr = 32'h4000;
        @(negedge clk);
        check("t1_bus_req_up", {31'b0, bus_req}, 32'd1);
        check("t1_bus_addr", bus_addr, 32'h4000);
        #2 rst = 1'b0;
        #1;
        check("t1_rst_outputs", {26'b0, bus_req, bus_write, if_valid, d_valid, if_stall, d_stall}, 32'h0);
        check("t1_rst_addr", bus_addr, 32'h0);
        d_req = 1'b0; d_addr = 32'h0;
        @(negedge clk) rst = 1'b1;

        // Fetch, zero wait (only requester after reset)
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h100;
        push(1'b0, 32'h13, 1'b0);
        #1 check("t2_stall_c0", {31'b0, if_stall}, 32'd1);
        @(negedge clk);
        check("t2_bus", {bus_req, bus_write, bus_size, bus_addr[27:0]}, {4'b1010, 28'h100});
        check("t2_stall_c1", {31'b0, if_stall}, 32'd1);
        bus_ack_n = 1'b0;
        @(negedge clk);
        check("t2_if_valid", {31'b0, if_valid}, 32'd1);
        check("t2_stall_c2", {31'b0, if_stall}, 32'd0);
        check("t2_bus_req_down", {31'b0, bus_req}, 32'd0);
        bus_ack_n = 1'b1; if_req = 1'b0;
        @(negedge clk);
        check("t2_pulse", {31'b0, if_valid}, 32'd0);

        // Simultaneous requests: data first, fetch 3 cycles later
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h180;
        d_req = 1'b1; d_write = 1'b0; d_size = 2'b10; d_addr = 32'h2000;
        bus_ack_n = 1'b0;
        push(1'b1, mem_word(32'h2000), 1'b0);
        push(1'b0, mem_word(32'h180), 1'b0);
        d_t = 0; i_t = 0; seen_addr = '0;
        @(negedge clk);
        check("t3_first_addr", bus_addr, 32'h2000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (d_valid) begin d_t = cyc; d_req = 1'b0; break; end
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_req) seen_addr = bus_addr;
            if (if_valid) begin i_t = cyc; if_req = 1'b0; break; end
        end
        check("t3_second_addr", seen_addr, 32'h180);
        check("t3_gap", 32'(i_t - d_t), 32'd3);
        bus_ack_n = 1'b1;

        // Store byte, three wait states
        @(negedge clk);
        d_req = 1'b1; d_write = 1'b1; d_size = 2'b00; d_addr = 32'h3003; d_wdata = 32'hAB;
        push(1'b1, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t4_ctl", {28'b0, bus_req, bus_write, bus_size}, 32'hC);
            check("t4_addr", bus_addr, 32'h3003);
            check("t4_wdata", bus_wdata, 32'hAB);
        end
        bus_ack_n = 1'b0;
        @(negedge clk);
        check("t4_d_valid", {31'b0, d_valid}, 32'd1);
        bus_ack_n = 1'b1; d_req = 1'b0; d_write = 1'b0;

        // Timeout, then a late ACK
        @(negedge clk);
        d_req = 1'b1; d_size = 2'b10; d_addr = 32'h4000;
        push(1'b1, 32'h0, 1'b1);
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (d_valid) break;
            if (bus_req) hi++;
        end
        check("t5_valid_seen", {31'b0, d_valid}, 32'd1);
        check("t5_req_cycles", 32'(hi), 32'd16);
        d_req = 1'b0; bus_ack_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_late_ack", {30'b0, bus_req, d_valid}, 32'd0);
        end
        bus_ack_n = 1'b1;

        // Misaligned word, misaligned half, illegal size
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            d_req = 1'b1; d_size = bad_sz[i]; d_addr = bad_ad[i];
            push(1'b1, 32'h0, 1'b1);
            @(negedge clk);
            check("t6_fault_valid", {31'b0, d_valid}, 32'd1);
            check("t6_no_bus", {31'b0, bus_req}, 32'd0);
            d_req = 1'b0;
            @(negedge clk);
        end

        // Flushed fetch: bus cycle completes, no if_valid
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h400;
        @(negedge clk);
        check("t6_flush_bus", {31'b0, bus_req}, 32'd1);
        @(negedge clk) if_req = 1'b0;
        @(negedge clk) bus_ack_n = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (if_valid) vcnt++;
        end
        check("t6_flush_no_valid", 32'(vcnt), 32'd0);
        check("t6_flush_bus_done", {31'b0, bus_req}, 32'd0);
        bus_ack_n = 1'b1;

        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
